// File: rtl/cnn_ctrl_pkg.sv
// ============================================================================
// Module      : cnn_ctrl_pkg
// Description : Shared types and constants for the convolution window
//               controller: FSM state encoding and the default kernel size.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_ctrl_pkg;

    // Default kernel size (KxK).
    localparam int K_DEF = 3;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/conv_window_ctrl_if.sv
// ============================================================================
// Module      : conv_window_ctrl_if
// Description : Pixel-stream and window handshake bundle of the convolution
//               window controller.
//               master : controller side (drives in_ready, lb_en, win_*)
//               slave  : pixel source / window consumer side
// Signals     : in_valid, in_ready, lb_en, win_valid, win_ready,
//               win_row[RW], win_col[CW]
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_window_ctrl_if #(
    parameter int CW = 2,
    parameter int RW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic          lb_en;
    logic          win_valid;
    logic          win_ready;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;

    modport master (
        input  in_valid, win_ready,
        output in_ready, lb_en, win_valid, win_row, win_col
    );

    modport slave (
        output in_valid, win_ready,
        input  in_ready, lb_en, win_valid, win_row, win_col
    );
endinterface

`default_nettype wire

// File: rtl/raster_pos_cnt.sv
// ============================================================================
// Module      : raster_pos_cnt
// Description : 2-D raster position counter. Column advances on i_adv and
//               wraps at IMG_W-1, stepping the row. o_last flags the final
//               pixel position of the frame.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_clr          - clear both counters
//               i_adv          - advance one pixel
//               o_col, o_row   - current pixel position
//               o_last         - position is (IMG_H-1, IMG_W-1)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module raster_pos_cnt #(
    parameter int IMG_W = 4,
    parameter int IMG_H = 4,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          i_clr,
    input  wire logic          i_adv,
    output logic      [CW-1:0] o_col,
    output logic      [RW-1:0] o_row,
    output logic               o_last
);
    localparam logic [CW-1:0] c_COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_adv) begin
            if (r_col == c_COL_MAX) begin
                r_col <= '0;
                r_row <= (r_row == c_ROW_MAX) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = (r_col == c_COL_MAX) && (r_row == c_ROW_MAX);

endmodule

`default_nettype wire

// File: rtl/conv_window_ctrl.sv
// ============================================================================
// Module      : conv_window_ctrl
// Description : Sequencing controller for a KxK convolution line-buffer
//               window datapath. Accepts a raster pixel stream, drives the
//               line-buffer shift enable, flags completed windows with their
//               top-left output coordinates and stalls on backpressure.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               start           - one-cycle frame start request
//               busy            - frame in progress
//               frame_done      - one-cycle end-of-frame pulse
//               bus (master)    - pixel and window handshake bundle
// Options     : CONV_CTRL_STRIDE2_EN - flag only windows whose output row
//               and column are both even (stride 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_ctrl
    import cnn_ctrl_pkg::*;
#(
    parameter int IMG_W = 4,
    parameter int IMG_H = 4,
    parameter int K     = K_DEF,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  wire logic   clk,
    input  wire logic   rst,
    input  wire logic   start,
    output logic        busy,
    output logic        frame_done,
    conv_window_ctrl_if.master bus
);
    generate
        if (K < 1 || K > IMG_W || K > IMG_H) begin : g_bad_kernel
            $error("conv_window_ctrl: K must satisfy 1 <= K <= IMG_W, IMG_H");
        end
    endgenerate

    localparam logic [CW-1:0] c_KM1_C = CW'(K - 1);
    localparam logic [RW-1:0] c_KM1_R = RW'(K - 1);

    ctrl_state_t   r_state;
    ctrl_state_t   w_state_nxt;

    logic          w_in_ready;
    logic          w_accept;
    logic          w_hs;
    logic          w_clr;
    logic          w_last;
    logic          w_win_ok;
    logic          w_new_win;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_ocol;
    logic [RW-1:0] w_orow;

    logic          r_win_valid;
    logic [RW-1:0] r_win_row;
    logic [CW-1:0] r_win_col;

    raster_pos_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CW    (CW),
        .RW    (RW)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_adv  (w_accept),
        .o_col  (w_col),
        .o_row  (w_row),
        .o_last (w_last)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_clr       = 1'b0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_clr       = 1'b1;
                end
            end
            RUN: begin
                busy       = 1'b1;
                // A pending window blocks the stream unless it leaves this cycle.
                w_in_ready = !r_win_valid || bus.win_ready;
                if (w_in_ready && bus.in_valid && w_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Stride builds may finish with no window outstanding.
                if (!r_win_valid || bus.win_ready) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_hs         = r_win_valid && bus.win_ready;
    assign bus.in_ready = w_in_ready;
    assign bus.lb_en    = w_accept;

    // ------------------------------------------------------------------
    // Window detection: the accepted pixel is the bottom-right corner.
    // ------------------------------------------------------------------
    assign w_win_ok = (w_row >= c_KM1_R) && (w_col >= c_KM1_C);
    assign w_orow   = w_row - c_KM1_R;
    assign w_ocol   = w_col - c_KM1_C;

`ifdef CONV_CTRL_STRIDE2_EN
    assign w_new_win = w_accept && w_win_ok && !w_orow[0] && !w_ocol[0];
`else
    assign w_new_win = w_accept && w_win_ok;
`endif

    // A new window overwrites one leaving in the same cycle, so back-to-back
    // windows carry no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_valid <= 1'b0;
            r_win_row   <= '0;
            r_win_col   <= '0;
        end else if (w_new_win) begin
            r_win_valid <= 1'b1;
            r_win_row   <= w_orow;
            r_win_col   <= w_ocol;
        end else if (w_hs) begin
            r_win_valid <= 1'b0;
        end
    end

    assign bus.win_valid = r_win_valid;
    assign bus.win_row   = r_win_row;
    assign bus.win_col   = r_win_col;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
// ============================================================================
// Module      : tb_conv_window_ctrl
// Description : Self-checking bench for conv_window_ctrl. A frame-level
//               reference model (pixel count, pending window, frame phase)
//               predicts every output each cycle; completed windows are also
//               checked against a raster-ordered list built from the frame
//               geometry.
// Options     : CONV_CTRL_STRIDE2_EN - selects the 6x6 stride-2 setup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_window_ctrl;

`ifdef CONV_CTRL_STRIDE2_EN
    localparam int IMG_W  = 6;
    localparam int IMG_H  = 6;
    localparam bit STRIDE = 1'b1;
`else
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 4;
    localparam bit STRIDE = 1'b0;
`endif
    localparam int K  = 3;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DONE  = 3;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic frame_done;

    conv_window_ctrl_if #(.CW(CW), .RW(RW)) bus ();

    conv_window_ctrl #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .CW    (CW),
        .RW    (RW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int m_phase = PH_IDLE;
    int m_cnt   = 0;
    bit m_pv    = 1'b0;
    int m_pr    = 0;
    int m_pc    = 0;

    // Per-frame observation
    int exp_r[$];
    int exp_c[$];
    int hs_idx;
    int n_lb;
    int n_done;

    function automatic bit win_at(input int r, input int c);
        if (r < K - 1 || c < K - 1) return 1'b0;
        if (STRIDE && (((r - K + 1) % 2) != 0 || ((c - K + 1) % 2) != 0)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int win_count();
        int nr, nc;
        nr = IMG_H - K + 1;
        nc = IMG_W - K + 1;
        if (STRIDE) begin
            nr = (nr + 1) / 2;
            nc = (nc + 1) / 2;
        end
        return nr * nc;
    endfunction

    task automatic frame_clear();
        exp_r.delete();
        exp_c.delete();
        for (int r = 0; r <= IMG_H - K; r++)
            for (int c = 0; c <= IMG_W - K; c++)
                if (!STRIDE || (r % 2 == 0 && c % 2 == 0)) begin
                    exp_r.push_back(r);
                    exp_c.push_back(c);
                end
        hs_idx = 0;
        n_lb   = 0;
        n_done = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs mid-cycle, then advance
    // the reference model across the rising edge.
    task automatic step(input logic iv, input logic wr, input logic st,
                        input logic rs, input bit chk);
        logic e_busy, e_rdy, e_lb, e_done, hs;
        int r, c;
        bus.in_valid  = iv;
        bus.win_ready = wr;
        start         = st;
        rst           = rs;
        @(negedge clk);
        e_busy = (m_phase == PH_RUN) || (m_phase == PH_DRAIN);
        e_rdy  = (m_phase == PH_RUN) && (!m_pv || wr);
        e_lb   = e_rdy && iv;
        e_done = (m_phase == PH_DONE);
        if (chk) begin
            total++;
            if ({busy, bus.in_ready, bus.lb_en, bus.win_valid, frame_done} !==
                {e_busy, e_rdy, e_lb, m_pv, e_done}) begin
                $display("FAIL ctrl_outputs t=%0t busy/in_ready/lb_en/win_valid/frame_done got %b%b%b%b%b want %b%b%b%b%b",
                         $time, busy, bus.in_ready, bus.lb_en, bus.win_valid, frame_done,
                         e_busy, e_rdy, e_lb, m_pv, e_done);
            end else passed++;
            if (m_pv) begin
                total++;
                if (bus.win_row !== RW'(m_pr) || bus.win_col !== CW'(m_pc))
                    $display("FAIL win_coord t=%0t got (%0d,%0d) want (%0d,%0d)",
                             $time, bus.win_row, bus.win_col, m_pr, m_pc);
                else passed++;
            end
            if (bus.lb_en === 1'b1) n_lb++;
            if (frame_done === 1'b1) n_done++;
            if (bus.win_valid === 1'b1 && wr) begin
                total++;
                if (hs_idx >= exp_r.size())
                    $display("FAIL win_order t=%0t extra window (%0d,%0d) got index %0d want < %0d",
                             $time, bus.win_row, bus.win_col, hs_idx, exp_r.size());
                else if (bus.win_row !== RW'(exp_r[hs_idx]) || bus.win_col !== CW'(exp_c[hs_idx]))
                    $display("FAIL win_order t=%0t idx %0d got (%0d,%0d) want (%0d,%0d)",
                             $time, hs_idx, bus.win_row, bus.win_col, exp_r[hs_idx], exp_c[hs_idx]);
                else passed++;
                hs_idx++;
            end
        end
        @(posedge clk);
        #1;
        hs = m_pv && wr;
        if (rs) begin
            m_phase = PH_IDLE;
            m_cnt   = 0;
            m_pv    = 1'b0;
            m_pr    = 0;
            m_pc    = 0;
        end else begin
            case (m_phase)
                PH_IDLE: if (st) begin
                    m_phase = PH_RUN;
                    m_cnt   = 0;
                end
                PH_RUN: begin
                    if (e_lb) begin
                        r = m_cnt / IMG_W;
                        c = m_cnt % IMG_W;
                        if (win_at(r, c)) begin
                            m_pv = 1'b1;
                            m_pr = r - (K - 1);
                            m_pc = c - (K - 1);
                        end else if (hs) m_pv = 1'b0;
                        m_cnt++;
                        if (m_cnt == IMG_W * IMG_H) m_phase = PH_DRAIN;
                    end else if (hs) m_pv = 1'b0;
                end
                PH_DRAIN: begin
                    if (!m_pv || hs) m_phase = PH_DONE;
                    if (hs) m_pv = 1'b0;
                end
                default: m_phase = PH_IDLE;
            endcase
        end
    endtask

    // mode: 0 stream, 1 backpressure on first window, 2 source gaps,
    //       3 random handshakes, 4 stream with stray start pulses
    task automatic run_frame(input int mode, input string tag);
        int   cyc, stall_left;
        bit   stalled;
        logic iv, wr, st;
        frame_clear();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc        = 0;
        stall_left = 0;
        stalled    = 1'b0;
        while (m_phase != PH_IDLE && cyc < 1000) begin
            iv = 1'b1;
            wr = 1'b1;
            st = 1'b0;
            case (mode)
                1: begin
                    if (!stalled && m_pv) begin
                        stalled    = 1'b1;
                        stall_left = 5;
                    end
                    if (stall_left > 0) begin
                        wr = 1'b0;
                        stall_left--;
                    end
                end
                2: iv = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                3: begin
                    iv = ($urandom_range(0, 3) != 0);
                    wr = ($urandom_range(0, 2) != 0);
                end
                4: st = $urandom_range(0, 1) != 0;
                default: ;
            endcase
            step(iv, wr, st, 1'b0, 1'b1);
            cyc++;
        end
        total++;
        if (cyc >= 1000) $display("FAIL %s frame_timeout got %0d cycles want < 1000", tag, cyc);
        else passed++;
        total++;
        if (hs_idx != win_count())
            $display("FAIL %s window_count got %0d want %0d", tag, hs_idx, win_count());
        else passed++;
        total++;
        if (n_lb != IMG_W * IMG_H)
            $display("FAIL %s lb_en_cycles got %0d want %0d", tag, n_lb, IMG_W * IMG_H);
        else passed++;
        total++;
        if (n_done != 1) $display("FAIL %s frame_done_pulses got %0d want 1", tag, n_done);
        else passed++;
    endtask

    task automatic test_reset();
        // Power-up cycle: DUT state is unknown until the first reset edge.
        step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1);
            total++;
            if (bus.win_row !== '0 || bus.win_col !== '0)
                $display("FAIL reset_coord got (%0d,%0d) want (0,0)", bus.win_row, bus.win_col);
            else passed++;
        end
        for (int i = 0; i < 4; i++) step(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stream();
        run_frame(0, "stream");
    endtask

    task automatic test_backpressure();
        run_frame(1, "backpressure");
    endtask

    task automatic test_source_gaps();
        run_frame(2, "source_gaps");
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) run_frame(3, "random");
    endtask

    task automatic test_reset_mid_frame();
        int k;
        frame_clear();
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        k = 0;
        while (m_cnt < 7 && k < 50) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            k++;
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        total++;
        if (bus.win_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0)
            $display("FAIL mid_reset_state got win_valid=%b busy=%b in_ready=%b want 0 0 0",
                     bus.win_valid, busy, bus.in_ready);
        else passed++;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        run_frame(4, "after_mid_reset");
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.win_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_source_gaps();
        test_random();
        test_reset_mid_frame();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    task automatic test_back_to_back();
        run_frame(0, "b2b_first");
        run_frame(4, "b2b_second");
    endtask

endmodule

`default_nettype wire

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
Sequencing controller for the line-buffer window datapath of a KxK convolution stage.
- Accepts a raster pixel stream with a valid/ready handshake and drives the line buffers' enable.
- Tracks row and column position within the frame.
- Flags when a complete KxK window is available and reports that window's output coordinates downstream.
- Propagates downstream backpressure by stalling the line buffers.
- Sits between the pixel source and the line_buffer/window-register/MAC array.

Parameters:
IMG_W, 4, frame width in pixels; equals the line_buffer WIDTH.
IMG_H, 4, frame height in pixels.
K, 3, kernel size; K <= IMG_W and K <= IMG_H, checked with an elaboration-time assertion.
CW, $clog2(IMG_W), column and output-column width.
RW, $clog2(IMG_H), row and output-row width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle frame start request.
busy  out  1  high from accepted start until frame_done.
in_valid  in  1  upstream pixel valid.
in_ready  out  1  controller can accept a pixel.
lb_en  out  1  line_buffer/window shift enable; combinational, equals in_valid & in_ready.
win_valid  out  1  a KxK window is complete (registered).
win_ready  in  1  downstream consumes the window.
win_row  out  RW  output row of the window (top-left pixel row).
win_col  out  CW  output column of the window.
frame_done  out  1  one-cycle pulse at end of frame.

Behaviour:
Reset, synchronous on clk with rst=1:
- state=IDLE, busy=0, in_ready=0, win_valid=0, win_row=0, win_col=0, frame_done=0.
- Internal row and col counters = 0.
- A reset mid-frame abandons the frame. Nothing is emitted afterwards. The line buffers are not cleared by this block.

FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=0. start=1 -> RUN, busy=1, counters cleared.
- RUN:
  - in_ready = !win_valid | win_ready.
  - Accept happens when in_valid & in_ready. On accept:
    - lb_en=1 in the same cycle.
    - col increments. At IMG_W-1, col wraps to 0 and row increments.
    - If the accepted pixel has row >= K-1 and col >= K-1, then next cycle win_valid=1, win_row=row-(K-1), win_col=col-(K-1).
  - A window handshake (win_valid & win_ready) with no new window clears win_valid.
  - A simultaneous handshake and new window loads the new window. There is no bubble.
  - Accepting pixel (IMG_H-1, IMG_W-1) -> DRAIN.
- DRAIN: in_ready=0. Wait for the last window handshake, then -> DONE.
- DONE: frame_done=1 for exactly one cycle, busy=0, -> IDLE.

Stall rules:
- While win_valid & !win_ready: win_valid, win_row and win_col hold; in_ready=0; lb_en=0.
- Counters change only on accept.
- in_valid low: no change.

Other rules:
- start while busy is ignored.
- Windows per frame = (IMG_H-K+1)*(IMG_W-K+1), emitted in raster order.
- Latency: 1 cycle from the accept of the completing pixel to win_valid.

Optional Feature:
CONV_CTRL_STRIDE2_EN:
- Defined: a window is flagged only when both its output row and output column are even; the frame window count is halved per dimension (rounded up). win_row and win_col still report pixel coordinates.
- Undefined: stride 1, as above.
- Pixel acceptance and lb_en are identical in both builds.

Decomposition:
- cnn_ctrl_pkg: state enum (IDLE/RUN/DRAIN/DONE) and the default kernel constant K_DEF=3.
- One sub-module, raster_pos_cnt: 2-D column/row counter with advance input, wrap at IMG_W, and a last-pixel flag. Instantiated once.

Test Plan:
1. Reset: hold rst 3 cycles with random inputs -> all outputs 0, in_ready=0, lb_en=0. After release with no start, the block stays idle.
2. Streaming: 4x4, K=3, start, then 16 pixels back-to-back with win_ready=1.
   - win_valid is high the cycle after pixels 11, 12, 15 and 16 (1-based), with (row,col) = (0,0), (0,1), (1,0), (1,1).
   - frame_done pulses 1 cycle after the last window handshake.
   - lb_en is high exactly 16 cycles.
3. Backpressure: win_ready=0 for 5 cycles when window (0,0) appears.
   - win_valid and (0,0) hold; in_ready=0 and lb_en=0 for those cycles.
   - After release, the remaining windows arrive in order and there are 4 windows total.
4. Source gaps: in_valid toggles 1,0,0,1 over the stream -> counters and lb_en follow accepts only; window coordinates match scenario 2.
5. Reset mid-frame after 7 accepts, then start and a full frame -> only the 4 correct windows appear and no stale win_valid. start pulses during RUN are ignored.
6. Stride build: with CONV_CTRL_STRIDE2_EN, 6x6, K=3, 36 pixels -> windows (0,0), (0,2), (2,0), (2,2) only, then frame_done.
